// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) arithmetic and the MixColumns engine FSM encoding.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package aes_pkg;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
  localparam logic [7:0] GF_RED = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  // Multiply by x in GF(2^8), reducing when the top bit shifts out.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_RED : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] a);
    return xtime(a);
  endfunction

  // 3*a = 2*a + a; addition in GF(2^8) is XOR.
  function automatic logic [7:0] mul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

endpackage

// File: rtl/gf_mix_column.sv
// Forward AES MixColumns on a single 4-byte column.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input.
// Ports: a0..a3 = input column rows 0..3, b0..b3 = product rows 0..3.
module gf_mix_column
  import aes_pkg::*;
(
  input  logic [7:0] a0,
  input  logic [7:0] a1,
  input  logic [7:0] a2,
  input  logic [7:0] a3,
  output logic [7:0] b0,
  output logic [7:0] b1,
  output logic [7:0] b2,
  output logic [7:0] b3
);

  // Circulant matrix rows: [02 03 01 01], [01 02 03 01], [01 01 02 03], [03 01 01 02].
  always_comb begin
    b0 = mul2(a0) ^ mul3(a1) ^ a2       ^ a3;
    b1 = a0       ^ mul2(a1) ^ mul3(a2) ^ a3;
    b2 = a0       ^ a1       ^ mul2(a2) ^ mul3(a3);
    b3 = mul3(a0) ^ a1       ^ a2       ^ mul2(a3);
  end

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential forward MixColumns: one column per clock through one shared column multiplier.
// Latency: 4 cycles from accept to out_valid; 1 cycle when in_bypass is set.
// Backpressure: result held stable in DONE until out_ready; in_ready only high in IDLE.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/in_state/in_bypass input handshake;
//        out_valid/out_ready/out_state output handshake; busy = block in flight.
module mix_columns_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  mc_state_e    fsm_q;
  mc_state_e    fsm_d;
  logic [127:0] state_q;
  logic [127:0] state_upd;
  logic         bypass_q;
  logic [1:0]   col_q;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // ---------------- FSM: next state ----------------
  // Bypassed blocks still spend one cycle in BUSY (without touching the data),
  // which gives the final round its one-cycle latency and 3-cycle cadence.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: if (in_valid)                  fsm_d = ST_BUSY;
      ST_BUSY: if (bypass_q || col_q == 2'd3) fsm_d = ST_DONE;
      ST_DONE: if (out_ready)                 fsm_d = ST_IDLE;
      default:                                fsm_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      ST_IDLE: in_ready = 1'b1;
      ST_BUSY: busy     = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  assign out_state = state_q;

  // ---------------- column select ----------------
  always_comb begin
    col_in = 32'h0;
    case (col_q)
      2'd0: col_in = state_q[127:96];
      2'd1: col_in = state_q[95:64];
      2'd2: col_in = state_q[63:32];
      2'd3: col_in = state_q[31:0];
      default: col_in = 32'h0;
    endcase
  end

  gf_mix_column u_col (
    .a0 (col_in[31:24]),
    .a1 (col_in[23:16]),
    .a2 (col_in[15:8]),
    .a3 (col_in[7:0]),
    .b0 (col_out[31:24]),
    .b1 (col_out[23:16]),
    .b2 (col_out[15:8]),
    .b3 (col_out[7:0])
  );

  // Write the product back over the column it was read from; others unchanged.
  always_comb begin
    state_upd = state_q;
    case (col_q)
      2'd0: state_upd[127:96] = col_out;
      2'd1: state_upd[95:64]  = col_out;
      2'd2: state_upd[63:32]  = col_out;
      2'd3: state_upd[31:0]   = col_out;
      default: state_upd = state_q;
    endcase
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= 128'h0;
      bypass_q <= 1'b0;
      col_q    <= 2'd0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_q  <= in_state;
            bypass_q <= in_bypass;
            col_q    <= 2'd0;
          end
        end
        ST_BUSY: begin
          if (!bypass_q) begin
            state_q <= state_upd;
            col_q   <= col_q + 2'd1;  // wraps 3 -> 0 on the last column
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
module tb_mix_columns_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int n_tests;
  int n_fail;

  mix_columns_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_bypass (in_bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic shift-and-add GF(2^8) multiply, independent of the xtime chain.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Circulant matrix multiply of every column; inv selects InvMixColumns.
  function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic inv);
    logic [7:0]   base [4];
    logic [127:0] o;
    logic [7:0]   acc;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gf_mul(base[(k - r + 4) % 4], s[127 - 32*c - 8*k -: 8]);
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  // Presents one block at a negedge; returns at the negedge after the accept edge.
  task automatic accept(input logic [127:0] s, input logic byp);
    @(negedge clk);
    in_valid  = 1'b1;
    in_state  = s;
    in_bypass = byp;
    @(negedge clk);
    in_valid  = 1'b0;
    in_bypass = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_tests++; if (out_state !== 128'h0) begin n_fail++; $display("FAIL rst_out_state: got %h want 0", out_state); end
    rst = 1'b0;
  endtask

  task automatic test_fips;
    logic [127:0] exp;
    exp = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    out_ready = 1'b1;
    accept(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL fips_latency E%0d: out_valid=%b busy=%b want 0/1", i, out_valid, busy);
      end
    end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL fips_valid_E4: got %b want 1", out_valid); end
    n_tests++; if (out_state !== exp) begin n_fail++; $display("FAIL fips_data: got %h want %h", out_state, exp); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL fips_release: out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_stall;
    logic [127:0] exp;
    exp = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;
    out_ready = 1'b0;
    accept(128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_state !== exp) begin
        n_fail++; $display("FAIL stall_hold cyc%0d: valid=%b in_ready=%b data=%h want 1/0/%h", i, out_valid, in_ready, out_state, exp);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_bypass;
    logic [127:0] v;
    out_ready = 1'b1;
    for (int n = 0; n < 2; n++) begin
      v = (n == 0) ? 128'h00112233_44556677_8899aabb_ccddeeff : 128'hdb135345_f20a225c_01010101_c6c6c6c6;
      accept(v, 1'b1);
      n_tests++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
        n_fail++; $display("FAIL byp_E0 #%0d: out_valid=%b busy=%b want 0/1", n, out_valid, busy);
      end
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || out_state !== v) begin
        n_fail++; $display("FAIL byp_data #%0d: valid=%b got %h want 1/%h", n, out_valid, out_state, v);
      end
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL byp_release #%0d: out_valid=%b in_ready=%b want 0/1", n, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_reset_busy;
    logic [127:0] exp;
    out_ready = 1'b1;
    accept(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_state !== 128'h0) begin
      n_fail++; $display("FAIL rstbusy_state: valid=%b busy=%b in_ready=%b data=%h want 0/0/1/0", out_valid, busy, in_ready, out_state);
    end
    rst = 1'b0;
    exp = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    accept(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1 || out_state !== exp) begin
      n_fail++; $display("FAIL rstbusy_after: valid=%b got %h want 1/%h", out_valid, out_state, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_input;
    logic [127:0] exp;
    exp = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    out_ready = 1'b0;
    accept(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b0);
    in_valid = 1'b1;
    in_bypass = 1'b1;
    in_state = 128'hffeeddcc_bbaa9988_77665544_33221100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_state = in_state ^ 128'h01;
      n_tests++; if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL ignore_in_ready cyc%0d: got %b want 0", i, in_ready);
      end
    end
    in_valid = 1'b0;
    in_bypass = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || out_state !== exp) begin
      n_fail++; $display("FAIL ignore_data: valid=%b got %h want 1/%h", out_valid, out_state, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL ignore_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_random;
    logic [127:0] s;
    logic [127:0] exp;
    out_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      s = {$urandom(), $urandom(), $urandom(), $urandom()};
      exp = mix_ref(s, 1'b0);
      accept(s, 1'b0);
      repeat (3) @(negedge clk);
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b1 || out_state !== exp) begin
        n_fail++; $display("FAIL rand_data #%0d: valid=%b got %h want 1/%h", n, out_valid, out_state, exp);
      end
      n_tests++; if (mix_ref(out_state, 1'b1) !== s) begin
        n_fail++; $display("FAIL rand_roundtrip #%0d: got %h want %h", n, mix_ref(out_state, 1'b1), s);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_state  = 128'h0;
    in_bypass = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_fips();
    test_stall();
    test_bypass();
    test_reset_busy();
    test_ignore_input();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
